// File: rtl/udp_cmd_pkg.sv
// rtl/udp_cmd_pkg.sv - opcodes, FSM states and error codes for the UDP command decoder
package udp_cmd_pkg;

   // ASCII opcode words, compared against the full FIFO word with upper bits zero
   localparam logic [31:0] OP_SEND = 32'h73656E64;   // "send"
   localparam logic [31:0] OP_STOP = 32'h73746F70;   // "stop"
   localparam logic [31:0] OP_RSET = 32'h72736574;   // "rset"
   localparam logic [31:0] OP_WREG = 32'h77726567;   // "wreg"

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      ARG_ADDR,
      ARG_DATA,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_UNKNOWN = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/udp_cmd_arg_timer.sv
// rtl/udp_cmd_arg_timer.sv - clearable stall counter guarding argument-word waits
module udp_cmd_arg_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic done
);

   // Counter only needs to reach TIMEOUT-1; done fires on the TIMEOUT-th stall cycle
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Stall counter: clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   // A zero TIMEOUT disables expiry entirely
   assign done = (TIMEOUT != 0) && inc && (count == LAST);

endmodule

// File: rtl/udp_cmd_decoder.sv
// rtl/udp_cmd_decoder.sv - decodes ASCII opcode words from the UDP receive FIFO
module udp_cmd_decoder
   import udp_cmd_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_ready,
   input  logic [DATA_W-1:0] data,
   output logic              rd_en,
   output logic              send_adc_data,
   output logic              stop_adc_data,
   output logic              soft_rst,
   output logic              reg_wr_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic              cmd_err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  cmd_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              busy
);

   state_t            state;
   logic [DATA_W-1:0] opcode;
   logic [ADDR_W-1:0] addr_q;
   logic              arg_state;
   logic              stall;
   logic              timer_done;

   assign arg_state = (state == ARG_ADDR) || (state == ARG_DATA);
   assign stall     = arg_state && !data_ready;
   assign busy      = (state != IDLE);

   // Pop whenever a word is wanted and present; gated by reset so nothing is consumed mid-reset
   assign rd_en = rst_n && data_ready && ((state == IDLE) || arg_state);

   udp_cmd_arg_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_arg_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!stall),
      .inc   (stall),
      .done  (timer_done)
   );

   // Command FSM with registered strobes, held register-write outputs and status counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         opcode        <= '0;
         addr_q        <= '0;
         send_adc_data <= 1'b0;
         stop_adc_data <= 1'b0;
         soft_rst      <= 1'b0;
         reg_wr_en     <= 1'b0;
         reg_addr      <= '0;
         reg_wr_data   <= '0;
         cmd_err       <= 1'b0;
         err_code      <= ERR_NONE;
         cmd_count     <= '0;
         err_count     <= '0;
      end else begin
         send_adc_data <= 1'b0;
         stop_adc_data <= 1'b0;
         soft_rst      <= 1'b0;
         reg_wr_en     <= 1'b0;
         cmd_err       <= 1'b0;
         case (state)
            IDLE: begin
               if (data_ready) begin
                  opcode <= data;
                  state  <= DECODE;
               end
            end
            DECODE: begin
               state <= IDLE;
               if (opcode == DATA_W'(OP_SEND)) begin
                  send_adc_data <= 1'b1;
                  cmd_count     <= cmd_count + CNT_W'(1);
               end else if (opcode == DATA_W'(OP_STOP)) begin
                  stop_adc_data <= 1'b1;
                  cmd_count     <= cmd_count + CNT_W'(1);
               end else if (opcode == DATA_W'(OP_RSET)) begin
                  soft_rst  <= 1'b1;
                  cmd_count <= cmd_count + CNT_W'(1);
               end else if (opcode == DATA_W'(OP_WREG)) begin
                  state <= ARG_ADDR;
               end else begin
                  cmd_err  <= 1'b1;
                  err_code <= ERR_UNKNOWN;
                  if (err_count != '1) err_count <= err_count + CNT_W'(1);
               end
            end
            ARG_ADDR: begin
               if (data_ready) begin
                  addr_q <= data[ADDR_W-1:0];
                  state  <= ARG_DATA;
               end else if (timer_done) begin
                  state <= ERR;
               end
            end
            ARG_DATA: begin
               if (data_ready) begin
                  reg_wr_en   <= 1'b1;
                  reg_addr    <= addr_q;
                  reg_wr_data <= data;
                  cmd_count   <= cmd_count + CNT_W'(1);
                  state       <= IDLE;
               end else if (timer_done) begin
                  state <= ERR;
               end
            end
            ERR: begin
               cmd_err  <= 1'b1;
               err_code <= ERR_TIMEOUT;
               if (err_count != '1) err_count <= err_count + CNT_W'(1);
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_cmd_decoder.sv
// tb/tb_udp_cmd_decoder.sv - directed self-checking bench for udp_cmd_decoder
module tb_udp_cmd_decoder;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;
   localparam int CNT_W  = 16;

   localparam logic [31:0] W_SEND = 32'h73656E64;
   localparam logic [31:0] W_STOP = 32'h73746F70;
   localparam logic [31:0] W_RSET = 32'h72736574;
   localparam logic [31:0] W_WREG = 32'h77726567;

   localparam int B_RD = 0, B_SEND = 1, B_STOP = 2, B_SRST = 3, B_WR = 4, B_ERR = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              data_ready;
   logic [DATA_W-1:0] data;
   logic              rd_en, send_adc_data, stop_adc_data, soft_rst, reg_wr_en, cmd_err, busy;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wr_data;
   logic [1:0]        err_code;
   logic [CNT_W-1:0]  cmd_count, err_count;

   logic [DATA_W-1:0] fifo[$];
   logic [5:0]        strb[64];
   int                cyc;
   int                n_checks = 0;
   int                n_errors = 0;

   always #5 clk = ~clk;

   udp_cmd_decoder #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (8),
      .CNT_W   (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_ready    (data_ready),
      .data          (data),
      .rd_en         (rd_en),
      .send_adc_data (send_adc_data),
      .stop_adc_data (stop_adc_data),
      .soft_rst      (soft_rst),
      .reg_wr_en     (reg_wr_en),
      .reg_addr      (reg_addr),
      .reg_wr_data   (reg_wr_data),
      .cmd_err       (cmd_err),
      .err_code      (err_code),
      .cmd_count     (cmd_count),
      .err_count     (err_count),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_inputs();
      data_ready = (fifo.size() != 0);
      data       = (fifo.size() != 0) ? fifo[0] : '0;
   endtask

   task automatic begin_test();
      cyc = 0;
      for (int i = 0; i < 64; i++) strb[i] = '0;
   endtask

   // One cycle: sample at negedge, pop the model FIFO if rd_en was high, drive #1 after posedge
   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (cyc < 64)
            strb[cyc] = {cmd_err, reg_wr_en, soft_rst, stop_adc_data, send_adc_data, rd_en};
         @(posedge clk);
         if (cyc < 64 && strb[cyc][B_RD]) void'(fifo.pop_front());
         cyc++;
         #1;
         drive_inputs();
      end
   endtask

   function automatic int first_hi(input int b);
      for (int i = 0; i < 64; i++) if (strb[i][b]) return i;
      return -1;
   endfunction

   function automatic int cnt_hi(input int b);
      int c = 0;
      for (int i = 0; i < 64; i++) if (strb[i][b]) c++;
      return c;
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      fifo.delete();
      drive_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      data_ready = 1'b1;
      data       = W_SEND;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd_en", rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_count", cmd_count, 0);
      check("rst_err_count", err_count, 0);
      check("rst_err_code", err_code, 0);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_strobes", {send_adc_data, stop_adc_data, soft_rst, reg_wr_en, cmd_err}, 0);

      // single send
      do_reset();
      begin_test();
      fifo.push_back(W_SEND);
      drive_inputs();
      run_cycles(6);
      check("send_rd_cyc", first_hi(B_RD), 0);
      check("send_cyc", first_hi(B_SEND), 2);
      check("send_cnt", cnt_hi(B_SEND), 1);
      check("send_cmd_count", cmd_count, 1);
      check("send_other", cnt_hi(B_STOP) + cnt_hi(B_SRST) + cnt_hi(B_WR) + cnt_hi(B_ERR), 0);

      // back-to-back stop, rset
      do_reset();
      begin_test();
      fifo.push_back(W_STOP);
      fifo.push_back(W_RSET);
      drive_inputs();
      run_cycles(8);
      check("stop_cyc", first_hi(B_STOP), 2);
      check("rset_cyc", first_hi(B_SRST), 4);
      check("b2b_rd_cnt", cnt_hi(B_RD), 2);
      check("b2b_cmd_count", cmd_count, 2);

      // register write
      do_reset();
      begin_test();
      fifo.push_back(W_WREG);
      fifo.push_back(32'h0000_0010);
      fifo.push_back(32'hDEAD_BEEF);
      drive_inputs();
      run_cycles(8);
      check("wreg_cyc", first_hi(B_WR), 4);
      check("wreg_cnt", cnt_hi(B_WR), 1);
      check("wreg_addr", reg_addr, 16'h0010);
      check("wreg_data", reg_wr_data, 32'hDEAD_BEEF);
      check("wreg_cmd_count", cmd_count, 1);

      // payload that looks like an opcode is data
      begin_test();
      fifo.push_back(W_WREG);
      fifo.push_back(32'hFFFF_0022);
      fifo.push_back(W_SEND);
      drive_inputs();
      run_cycles(8);
      check("payload_wr_cnt", cnt_hi(B_WR), 1);
      check("payload_send_cnt", cnt_hi(B_SEND), 0);
      check("payload_addr", reg_addr, 16'h0022);
      check("payload_data", reg_wr_data, W_SEND);
      check("payload_cmd_count", cmd_count, 2);

      // unknown opcode
      do_reset();
      begin_test();
      fifo.push_back(32'h1234_5678);
      drive_inputs();
      run_cycles(6);
      check("unk_err_cyc", first_hi(B_ERR), 2);
      check("unk_err_cnt", cnt_hi(B_ERR), 1);
      check("unk_err_code", err_code, 1);
      check("unk_err_count", err_count, 1);
      check("unk_cmd_count", cmd_count, 0);
      check("unk_other", cnt_hi(B_SEND) + cnt_hi(B_STOP) + cnt_hi(B_SRST) + cnt_hi(B_WR), 0);

      // timeout after exactly 8 stall cycles, then a normal send
      do_reset();
      begin_test();
      fifo.push_back(W_WREG);
      drive_inputs();
      run_cycles(16);
      check("to_err_cyc", first_hi(B_ERR), 11);
      check("to_err_cnt", cnt_hi(B_ERR), 1);
      check("to_err_code", err_code, 2);
      check("to_err_count", err_count, 1);
      check("to_busy", busy, 0);
      begin_test();
      fifo.push_back(W_SEND);
      drive_inputs();
      run_cycles(5);
      check("to_send_cyc", first_hi(B_SEND), 2);
      check("to_cmd_count", cmd_count, 1);
      check("to_err_count2", err_count, 1);

      // 7 stall cycles then the arguments arrive: no timeout
      do_reset();
      begin_test();
      fifo.push_back(W_WREG);
      drive_inputs();
      run_cycles(9);
      fifo.push_back(32'h0000_0033);
      fifo.push_back(32'h0BAD_F00D);
      drive_inputs();
      run_cycles(5);
      check("edge_wr_cyc", first_hi(B_WR), 11);
      check("edge_err_cnt", cnt_hi(B_ERR), 0);
      check("edge_data", reg_wr_data, 32'h0BAD_F00D);

      // reset while waiting in ARG_DATA
      do_reset();
      begin_test();
      fifo.push_back(W_WREG);
      fifo.push_back(32'h0000_0010);
      fifo.push_back(32'hAAAA_5555);
      fifo.push_back(W_WREG);
      fifo.push_back(32'h0000_0020);
      drive_inputs();
      run_cycles(8);
      check("mid_busy_pre", busy, 1);
      check("mid_cmd_pre", cmd_count, 1);
      fifo.push_back(32'hBBBB_BBBB);
      rst_n = 1'b0;
      drive_inputs();
      #1;
      check("mid_busy", busy, 0);
      check("mid_rd_en", rd_en, 0);
      check("mid_cmd_count", cmd_count, 0);
      check("mid_reg_addr", reg_addr, 0);
      check("mid_reg_data", reg_wr_data, 0);
      begin_test();
      run_cycles(3);
      check("mid_rst_rd_cnt", cnt_hi(B_RD), 0);
      check("mid_rst_wr_cnt", cnt_hi(B_WR), 0);
      fifo.delete();
      rst_n = 1'b1;
      drive_inputs();
      begin_test();
      run_cycles(3);
      check("mid_post_wr_cnt", cnt_hi(B_WR), 0);
      check("mid_post_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/udp_cmd_decoder.md
# udp_cmd_decoder

Parametrised command decoder between the UDP receive FIFO and the ADC capture and control logic. It pops ASCII opcode words from the FIFO and decodes a fixed command set: send, stop, soft reset and register write. The register-write command carries two argument words, and the block enforces an argument timeout. It reports errors and keeps command and error counters for status readback.

## Interface
- DATA_W, 32: FIFO word width, >= 32.
- ADDR_W, 16: register address width, taken from arg word bits [ADDR_W-1:0].
- TIMEOUT, 1024: maximum stall cycles while waiting for an argument word; 0 disables the timeout.
- CNT_W, 16: width of the status counters.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_ready  in  1  FIFO non-empty; `data` holds the head word (first-word fall-through).
- data  in  DATA_W  FIFO head word.
- rd_en  out  1  pop; the head word is consumed at the next clk edge.
- send_adc_data  out  1  one-cycle strobe.
- stop_adc_data  out  1  one-cycle strobe.
- soft_rst  out  1  one-cycle strobe.
- reg_wr_en  out  1  one-cycle register-write strobe.
- reg_addr  out  ADDR_W  held until the next write.
- reg_wr_data  out  DATA_W  held until the next write.
- cmd_err  out  1  one-cycle error strobe.
- err_code  out  2  0 = none, 1 = unknown opcode, 2 = argument timeout; held until the next error.
- cmd_count  out  CNT_W  count of executed commands; wraps.
- err_count  out  CNT_W  count of errors; saturates at all-ones.
- busy  out  1  state != IDLE.

## Operation
- Opcodes compare on the full word, with upper bits zero:
  - send = 32'h73656E64
  - stop = 32'h73746F70
  - rset = 32'h72736574
  - wreg = 32'h77726567
- State machine:
  - IDLE: if data_ready, assert rd_en, register the opcode, go to DECODE.
  - DECODE: for send, stop or rset, register the matching strobe and go to IDLE. For wreg, clear the timer and go to ARG_ADDR. For any other value, register cmd_err with err_code=1 and go to IDLE.
  - ARG_ADDR: if data_ready, assert rd_en, latch the address, clear the timer, go to ARG_DATA. Otherwise increment the timer. If the timer reaches TIMEOUT (and TIMEOUT != 0), go to ERR.
  - ARG_DATA: if data_ready, assert rd_en and register reg_wr_en, reg_addr and reg_wr_data, then go to IDLE. The timeout applies here exactly as in ARG_ADDR.
  - ERR: register cmd_err with err_code=2, discard the partial command, go to IDLE.
- rd_en is combinational: (state is IDLE, ARG_ADDR or ARG_DATA) && data_ready. It is never asserted while data_ready=0, and it is forced to 0 while rst_n=0.
- cmd_count increments once per executed send, stop, rset or wreg.
- err_count increments once per cmd_err strobe.
- soft_rst is an output only; it does not reset this block.
- A wreg payload word that matches an opcode is treated as data, never as a command.

## Timing
- Cycle n is the period after clk edge n.
- No-argument command: rd_en is high in cycle 0, DECODE occurs in cycle 1, and the strobe is high in cycle 2 only. IDLE is re-entered in cycle 2, so the next pop can happen in cycle 2. Peak rate is one command per 2 cycles.
- wreg: when the data word is popped in cycle k, reg_wr_en, reg_addr and reg_wr_data are valid in cycle k+1.
- Timeout: the ERR state is entered after exactly TIMEOUT consecutive cycles with data_ready=0. cmd_err goes high the cycle after ERR.
- cmd_count and err_count update in the same cycle their strobe is high.
- Reset values (asynchronous): state IDLE, all strobes 0, reg_addr 0, reg_wr_data 0, err_code 0, both counters 0, timer 0. busy=0 and rd_en=0.
- Reset asserted mid-command aborts the command. No strobe is produced for the aborted command and the FIFO is not popped further.

## Structure
- Package udp_cmd_pkg holds:
  - the four opcode localparams,
  - the state_t enum (IDLE, DECODE, ARG_ADDR, ARG_DATA, ERR),
  - err_code localparams.
- Sub-module udp_cmd_arg_timer holds the clearable stall counter, parameter TIMEOUT, and a done output.
- The FSM, output registers and status counters live in the top module.

## Test plan
- "send" word with data_ready=1 from cycle 0 -> rd_en high in cycle 0, send_adc_data high in cycle 2 only, cmd_count=1.
- Back-to-back "stop" then "rset" words present in the FIFO -> stop_adc_data in cycle 2, soft_rst in cycle 4, cmd_count=2.
- Words "wreg", 32'h0000_0010, 32'hDEAD_BEEF -> one reg_wr_en with reg_addr=16'h0010 and reg_wr_data=32'hDEAD_BEEF; cmd_count=1.
- Word 32'h1234_5678 -> cmd_err one cycle, err_code=1, err_count=1, no other strobe.
- TIMEOUT=8, "wreg" followed by the FIFO staying empty -> cmd_err with err_code=2 after 8 stall cycles. A "send" arriving later executes normally.
- rst_n pulsed low while in ARG_DATA -> all outputs and counters read 0 immediately, no reg_wr_en, rd_en=0 during reset.
